// File: rtl/mips_pkg.sv
// Shared register-file types and constants for the MIPS write-back path.
// Write-source tags, the round-robin pointer type and the debug view struct live here.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LD   = 2'd2,
        WB_MD   = 2'd3
    } wb_src_t;

    // Pointer names the side that wins the next contended grant.
    typedef enum logic {
        RR_LD = 1'b0,
        RR_MD = 1'b1
    } rr_ptr_t;

    typedef struct packed {
        rr_ptr_t rr;
        wb_src_t src;
    } wb_dbg_t;

    function automatic rr_ptr_t rr_other(input rr_ptr_t p);
        return (p == RR_LD) ? RR_MD : RR_LD;
    endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of producer requests, register-file write port and scoreboard signals
// between the execution units and the write-back arbiter.
interface regfile_writeback_if #(
    parameter int DATA_W = mips_pkg::REG_DATA_W,
    parameter int ADDR_W = mips_pkg::REG_ADDR_W
);

    // Handshake: a result moves on a cycle where x_valid && x_ready. A producer
    // holds valid/addr/data stable until that cycle; ready is combinational and
    // may be high without valid, which then has no effect. ALU has no ready.
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              md_valid;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;

    logic              enc;
    logic [ADDR_W-1:0] addrc;
    logic [DATA_W-1:0] datac;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_addr;
    logic [31:0]       busy;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output md_valid, md_addr, md_data,
        output issue_valid, issue_addr,
        input  ld_ready, md_ready,
        input  enc, addrc, datac, busy
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  md_valid, md_addr, md_data,
        input  issue_valid, issue_addr,
        output ld_ready, md_ready,
        output enc, addrc, datac, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter (load vs mul/div) with an external block input.
// The pointer only moves on a contended grant, so a lone requester never steals a turn.
module rr_arbiter2
    import mips_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    block_i,
    input  logic    req_ld_i,
    input  logic    req_md_i,
    output logic    gnt_ld_o,
    output logic    gnt_md_o,
    output rr_ptr_t rr_o
);

    rr_ptr_t rr_q, rr_d;

    always_comb begin
        gnt_ld_o = 1'b0;
        gnt_md_o = 1'b0;
        rr_d     = rr_q;
        if (!block_i) begin
            if (req_ld_i && req_md_i) begin
                if (rr_q == RR_LD) begin
                    gnt_ld_o = 1'b1;
                end else begin
                    gnt_md_o = 1'b1;
                end
                rr_d = rr_other(rr_q);
            end else begin
                gnt_ld_o = req_ld_i;
                gnt_md_o = req_md_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= RR_LD;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign rr_o = rr_q;

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: ALU has fixed priority, load and mul/div share
// the remaining slots round-robin. Define WB_SCOREBOARD_EN to build the busy-bit scoreboard.
module regfile_writeback
    import mips_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic               clock,
    input  logic               reset,
    regfile_writeback_if.slave wb,
    output wb_dbg_t            dbg_o
);

    logic              ld_gnt, md_gnt;
    rr_ptr_t           rr;

    wb_src_t           win_src;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              xfer;

    logic              enc_q, enc_d;
    logic [ADDR_W-1:0] addrc_q, addrc_d;
    logic [DATA_W-1:0] datac_q, datac_d;

    rr_arbiter2 u_rr (
        .clk_i    (clock),
        .rst_ni   (reset),
        .block_i  (wb.alu_valid),
        .req_ld_i (wb.ld_valid),
        .req_md_i (wb.md_valid),
        .gnt_ld_o (ld_gnt),
        .gnt_md_o (md_gnt),
        .rr_o     (rr)
    );

    assign wb.ld_ready = ld_gnt;
    assign wb.md_ready = md_gnt;

    always_comb begin
        win_src  = WB_NONE;
        win_addr = '0;
        win_data = '0;
        if (wb.alu_valid) begin
            win_src  = WB_ALU;
            win_addr = wb.alu_addr;
            win_data = wb.alu_data;
        end else if (ld_gnt) begin
            win_src  = WB_LD;
            win_addr = wb.ld_addr;
            win_data = wb.ld_data;
        end else if (md_gnt) begin
            win_src  = WB_MD;
            win_addr = wb.md_addr;
            win_data = wb.md_data;
        end
    end

    assign xfer = (win_src != WB_NONE);

    // A write to $0 is consumed like any other, it just never enables the port.
    always_comb begin
        enc_d   = xfer && (win_addr != '0);
        addrc_d = xfer ? win_addr : addrc_q;
        datac_d = xfer ? win_data : datac_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enc_q   <= 1'b0;
            addrc_q <= '0;
            datac_q <= '0;
        end else begin
            enc_q   <= enc_d;
            addrc_q <= addrc_d;
            datac_q <= datac_d;
        end
    end

    assign wb.enc   = enc_q;
    assign wb.addrc = addrc_q;
    assign wb.datac = datac_q;

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Clear first, then set, so an issue on the retiring register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (enc_q) begin
            busy_d[addrc_q] = 1'b0;
        end
        if (wb.issue_valid) begin
            busy_d[wb.issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign wb.busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{wb.issue_valid, wb.issue_addr};
    assign wb.busy      = '0;
`endif

    assign dbg_o = {rr, win_src};

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: vector table, hand sequences for reset
// and scoreboard corners, and a randomized phase checked against a behavioural model.
module tb_regfile_writeback;
    import mips_pkg::*;

    localparam int OUT_W = 1 + 5 + 32;
    localparam logic [31:0] LD0 = 32'h1D00_000A;
    localparam logic [31:0] MD0 = 32'h3D00_000B;
    localparam logic [31:0] LD1 = 32'h1D00_000C;
    localparam logic [31:0] MD1 = 32'h3D00_000D;
    localparam logic [31:0] MD2 = 32'h3D00_001F;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        ld_v;
        logic [4:0]  ld_a;
        logic [31:0] ld_d;
        logic        md_v;
        logic [4:0]  md_a;
        logic [31:0] md_d;
        logic        e_ld_rdy;
        logic        e_md_rdy;
        logic        e_enc;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    logic    clk;
    logic    rst_n;
    wb_dbg_t dbg;
    int      n_cmp;
    int      n_err;
    logic [OUT_W-1:0] exp_q[$];
    vec_t    tbl[12];

    regfile_writeback_if #(.DATA_W(32), .ADDR_W(5)) wb ();

    regfile_writeback #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock (clk),
        .reset (rst_n),
        .wb    (wb),
        .dbg_o (dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic vec_t mk(
        input logic alu_v, input logic [4:0] alu_a, input logic [31:0] alu_d,
        input logic ld_v, input logic [4:0] ld_a, input logic [31:0] ld_d,
        input logic md_v, input logic [4:0] md_a, input logic [31:0] md_d,
        input logic e_ld, input logic e_md,
        input logic e_enc, input logic [4:0] e_addr, input logic [31:0] e_data);
        vec_t v;
        v.alu_v = alu_v; v.alu_a = alu_a; v.alu_d = alu_d;
        v.ld_v = ld_v;   v.ld_a = ld_a;   v.ld_d = ld_d;
        v.md_v = md_v;   v.md_a = md_a;   v.md_d = md_d;
        v.e_ld_rdy = e_ld; v.e_md_rdy = e_md;
        v.e_enc = e_enc; v.e_addr = e_addr; v.e_data = e_data;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        wb.alu_valid = 1'b0; wb.alu_addr = '0; wb.alu_data = '0;
        wb.ld_valid  = 1'b0; wb.ld_addr  = '0; wb.ld_data  = '0;
        wb.md_valid  = 1'b0; wb.md_addr  = '0; wb.md_data  = '0;
    endtask

    // Entered and left on a falling edge; one rising edge in between.
    task automatic step(input vec_t v);
        logic [OUT_W-1:0] e;
        wb.alu_valid = v.alu_v; wb.alu_addr = v.alu_a; wb.alu_data = v.alu_d;
        wb.ld_valid  = v.ld_v;  wb.ld_addr  = v.ld_a;  wb.ld_data  = v.ld_d;
        wb.md_valid  = v.md_v;  wb.md_addr  = v.md_a;  wb.md_data  = v.md_d;
        #1;
        if (v.ld_v || v.alu_v) cmp("ld_ready", {31'd0, wb.ld_ready}, {31'd0, v.e_ld_rdy});
        if (v.md_v || v.alu_v) cmp("md_ready", {31'd0, wb.md_ready}, {31'd0, v.e_md_rdy});
        exp_q.push_back({v.e_enc, v.e_addr, v.e_data});
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        cmp("enc",   {31'd0, wb.enc},   {31'd0, e[37]});
        cmp("addrc", {27'd0, wb.addrc}, {27'd0, e[36:32]});
        cmp("datac", wb.datac, e[31:0]);
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        #1;
        cmp("rst_enc",   {31'd0, wb.enc}, 32'd0);
        cmp("rst_addrc", {27'd0, wb.addrc}, 32'd0);
        cmp("rst_datac", wb.datac, 32'd0);
        cmp("rst_busy",  wb.busy, 32'd0);
        cmp("rst_rr",    {31'd0, dbg.rr}, {31'd0, RR_LD});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        logic       rr_m;
        logic       ld_p, md_p;
        logic [4:0] la, ma, pa, wa;
        logic [31:0] ld, md, pd, wd;
        logic       won, e_ld, e_md;

        n_cmp = 0;
        n_err = 0;
        wb.issue_valid = 1'b0;
        wb.issue_addr  = '0;
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        apply_reset();

        tbl[0]  = mk(1, 5, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234_5678);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h1234_5678);
        tbl[2]  = mk(1, 1, 32'hA1, 1, 10, LD0, 1, 11, MD0, 0, 0, 1, 1, 32'hA1);
        tbl[3]  = mk(1, 2, 32'hA2, 1, 10, LD0, 1, 11, MD0, 0, 0, 1, 2, 32'hA2);
        tbl[4]  = mk(1, 3, 32'hA3, 1, 10, LD0, 1, 11, MD0, 0, 0, 1, 3, 32'hA3);
        tbl[5]  = mk(0, 0, 0, 1, 10, LD0, 1, 11, MD0, 1, 0, 1, 10, LD0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 11, MD0, 0, 1, 1, 11, MD0);
        tbl[7]  = mk(0, 0, 0, 1, 12, LD1, 1, 13, MD1, 0, 1, 1, 13, MD1);
        tbl[8]  = mk(0, 0, 0, 1, 12, LD1, 0, 0, 0, 1, 0, 1, 12, LD1);
        tbl[9]  = mk(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 31, MD2, 0, 1, 1, 31, MD2);

        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Reset while a write is on the port; pointer left favouring mul/div first.
        step(mk(0, 0, 0, 1, 14, LD0, 1, 15, MD0, 1, 0, 1, 14, LD0));
        step(mk(1, 6, 32'h66, 0, 0, 0, 1, 15, MD0, 0, 0, 1, 6, 32'h66));
        cmp("pre_rst_enc", {31'd0, wb.enc}, 32'd1);
        apply_reset();
        step(mk(0, 0, 0, 1, 8, LD1, 1, 9, MD1, 1, 0, 1, 8, LD1));
        step(mk(0, 0, 0, 0, 0, 0, 1, 9, MD1, 0, 1, 1, 9, MD1));

`ifdef WB_SCOREBOARD_EN
        wb.issue_valid = 1'b1; wb.issue_addr = 5'd7;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, MD1));
        wb.issue_valid = 1'b0;
        cmp("busy7_set", {31'd0, wb.busy[7]}, 32'd1);
        step(mk(1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77));
        cmp("busy7_hold", {31'd0, wb.busy[7]}, 32'd1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h77));
        cmp("busy7_clr", {31'd0, wb.busy[7]}, 32'd0);
        step(mk(1, 7, 32'h78, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h78));
        wb.issue_valid = 1'b1; wb.issue_addr = 5'd7;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h78));
        wb.issue_addr = 5'd0;
        cmp("busy7_setwins", {31'd0, wb.busy[7]}, 32'd1);
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h78));
        wb.issue_valid = 1'b0;
        cmp("busy_all", wb.busy, 32'h0000_0080);
`else
        wb.issue_valid = 1'b1; wb.issue_addr = 5'd7;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, MD1));
        wb.issue_valid = 1'b0;
        cmp("busy_tied", wb.busy, 32'd0);
`endif

        // Randomized traffic against a behavioural model, starting from reset.
        apply_reset();
        rr_m = 1'b0; ld_p = 1'b0; md_p = 1'b0;
        pa = '0; pd = '0; la = '0; ma = '0; ld = '0; md = '0;
        for (int c = 0; c < 80; c++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.alu_v = ($urandom_range(0, 3) == 0);
            v.alu_a = 5'($urandom_range(0, 31));
            v.alu_d = $urandom;
            if (!ld_p && ($urandom_range(0, 1) == 1)) begin
                ld_p = 1'b1; la = 5'($urandom_range(0, 31)); ld = $urandom;
            end
            if (!md_p && ($urandom_range(0, 1) == 1)) begin
                md_p = 1'b1; ma = 5'($urandom_range(0, 31)); md = $urandom;
            end
            v.ld_v = ld_p; v.ld_a = la; v.ld_d = ld;
            v.md_v = md_p; v.md_a = ma; v.md_d = md;
            won = 1'b1; e_ld = 1'b0; e_md = 1'b0; wa = '0; wd = '0;
            if (v.alu_v) begin
                wa = v.alu_a; wd = v.alu_d;
            end else if (ld_p && md_p) begin
                if (!rr_m) e_ld = 1'b1; else e_md = 1'b1;
                rr_m = ~rr_m;
            end else if (ld_p) begin
                e_ld = 1'b1;
            end else if (md_p) begin
                e_md = 1'b1;
            end else begin
                won = 1'b0;
            end
            if (e_ld) begin wa = la; wd = ld; ld_p = 1'b0; end
            if (e_md) begin wa = ma; wd = md; md_p = 1'b0; end
            if (won) begin pa = wa; pd = wd; end
            v.e_ld_rdy = e_ld; v.e_md_rdy = e_md;
            v.e_enc = won && (wa != 5'd0);
            v.e_addr = pa; v.e_data = pd;
            step(v);
        end
        drive_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
